// File: rtl/processor_pkg.sv
// Shared definitions for the multicore processor build: arbiter state encodings,
// default datapath widths and a constant-function ceil(log2) helper.
package processor_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_ACK   = 2'd3
    } arb_state_t;

    localparam int DEF_N_CORES = 4;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_MEM_LAT = 2;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_select.sv
// Rotating-priority picker: returns the first pending index after ptr, wrapping modulo N_CORES.
module rr_select #(
    parameter int N_CORES = 4,
    parameter int ID_W    = 2
) (
    input  logic [N_CORES-1:0] pending,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    sel,
    output logic               any
);

    logic [ID_W-1:0] idx;

    // Scan from the farthest candidate back to the nearest so the nearest pending core wins.
    always_comb begin
        sel = '0;
        any = 1'b0;
        idx = '0;
        for (int k = N_CORES; k >= 1; k--) begin
            idx = ID_W'((int'(ptr) + k) % N_CORES);
            if (pending[idx]) begin
                sel = idx;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one data RAM between several cores: buffers one strobed
// request per core, runs one RAM access at a time and returns a one-cycle ack with read data.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ARB_IDLE  | no access in flight; grant when start and a request is pending
//   ARB_ISSUE | address/data presented to RAM, mem_we pulses here for writes
//   ARB_WAIT  | RAM latency, MEM_LAT cycles, address held
//   ARB_ACK   | ack to served core; chain straight into the next grant if possible
module data_mem_arbiter
    import processor_pkg::*;
#(
    parameter int N_CORES = DEF_N_CORES,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MEM_LAT = DEF_MEM_LAT,
    localparam int ID_W   = (clog2(N_CORES) > 0) ? clog2(N_CORES) : 1
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [N_CORES-1:0]         req,
    input  logic [N_CORES-1:0]         we,
    input  logic [N_CORES*ADDR_W-1:0]  addr,
    input  logic [N_CORES*DATA_W-1:0]  wdata,
    output logic [N_CORES-1:0]         ack,
    output logic [DATA_W-1:0]          rdata,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    output logic                       mem_we,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       busy,
    output logic [ID_W-1:0]            grant_id
);

    localparam int CNT_W = (clog2(MEM_LAT + 1) > 0) ? clog2(MEM_LAT + 1) : 1;

    arb_state_t        state;
    logic [N_CORES-1:0] pending;
    logic [N_CORES-1:0] accept;
    logic [N_CORES-1:0] clr;
    logic [ADDR_W-1:0] slot_addr  [N_CORES];
    logic [DATA_W-1:0] slot_wdata [N_CORES];
    logic              slot_we    [N_CORES];
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   sel;
    logic              any;
    logic              in_service;
    logic              grant_now;
    logic              cur_we;
    logic [CNT_W-1:0]  wait_cnt;

    rr_select #(
        .N_CORES (N_CORES),
        .ID_W    (ID_W)
    ) u_rr_select (
        .pending (pending),
        .ptr     (ptr),
        .sel     (sel),
        .any     (any)
    );

    assign busy       = (state != ARB_IDLE);
    assign in_service = (state == ARB_ISSUE) || (state == ARB_WAIT);
    assign grant_now  = start && any && ((state == ARB_IDLE) || (state == ARB_ACK));
    assign clr        = grant_now ? (N_CORES'(1) << sel) : '0;

    // A core that is already queued or mid-access cannot overwrite its slot; re-strobing in ACK is legal.
    always_comb begin
        accept = '0;
        for (int i = 0; i < N_CORES; i++) begin
            accept[i] = req[i] && !pending[i] && !(in_service && (grant_id == ID_W'(i)));
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ARB_IDLE;
            pending   <= '0;
            ptr       <= ID_W'(N_CORES - 1);
            ack       <= '0;
            rdata     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            grant_id  <= '0;
            cur_we    <= 1'b0;
            wait_cnt  <= '0;
            for (int i = 0; i < N_CORES; i++) begin
                slot_addr[i]  <= '0;
                slot_wdata[i] <= '0;
                slot_we[i]    <= 1'b0;
            end
        end else begin
            for (int i = 0; i < N_CORES; i++) begin
                if (accept[i]) begin
                    slot_addr[i]  <= addr[i*ADDR_W +: ADDR_W];
                    slot_wdata[i] <= wdata[i*DATA_W +: DATA_W];
                    slot_we[i]    <= we[i];
                end
            end
            pending <= (pending & ~clr) | accept;
            ack     <= '0;
            mem_we  <= 1'b0;

            case (state)
                ARB_IDLE, ARB_ACK: begin
                    if (grant_now) begin
                        state     <= ARB_ISSUE;
                        mem_addr  <= slot_addr[sel];
                        mem_wdata <= slot_wdata[sel];
                        mem_we    <= slot_we[sel];
                        cur_we    <= slot_we[sel];
                        grant_id  <= sel;
                        ptr       <= sel;
                    end else begin
                        state <= ARB_IDLE;
                    end
                end
                ARB_ISSUE: begin
                    state    <= ARB_WAIT;
                    wait_cnt <= CNT_W'(MEM_LAT - 1);
                end
                ARB_WAIT: begin
                    if (wait_cnt == '0) begin
                        state         <= ARB_ACK;
                        ack[grant_id] <= 1'b1;
                        if (!cur_we) begin
                            rdata <= mem_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: single-access vector table, then hand-built
// contention, fairness, start-gating and mid-access reset sequences.
module tb_data_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 16;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            start;
    logic [N-1:0]    req;
    logic [N-1:0]    we;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    ack;
    logic [DW-1:0]   rdata;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_we;
    logic [DW-1:0]   mem_rdata;
    logic            busy;
    logic [1:0]      grant_id;

    data_mem_arbiter #(
        .N_CORES (N),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .MEM_LAT (2)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .ack       (ack),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clock = ~clock;

    // RAM model with a two-cycle read pipeline: data appears two edges after the address settles.
    logic [DW-1:0] ram [256];
    logic [DW-1:0] rd1;
    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;

    always @(posedge clock) begin
        if (pl_en) ram[pl_addr] <= pl_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        rd1       <= ram[mem_addr];
        mem_rdata <= rd1;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic set_core(input int c, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        we[c] = w;
        addr[c*AW +: AW] = a;
        wdata[c*DW +: DW] = d;
    endtask

    int            ev_t   [8];
    logic [N-1:0]  ev_ack [8];
    logic [DW-1:0] ev_rd  [8];
    int            n_ev;

    // Runs nt cycles after a strobe edge, logging acks. mode 1: core 0 re-strobes in its ACK
    // cycles (twice) and core 3 strobes once; mode 2: start dropped mid-WAIT and restored later.
    task automatic collect(input int nt, input int mode);
        int rs;
        rs = 0;
        n_ev = 0;
        for (int k = 0; k < 8; k++) begin
            ev_t[k] = -1; ev_ack[k] = '0; ev_rd[k] = '0;
        end
        for (int t = 1; t <= nt; t++) begin
            tick();
            if (ack != '0 && n_ev < 8) begin
                ev_t[n_ev] = t; ev_ack[n_ev] = ack; ev_rd[n_ev] = rdata;
                n_ev++;
            end
            req = '0;
            if (mode == 1) begin
                if (ack[0] && rs < 2) begin
                    req[0] = 1'b1;
                    rs++;
                end
                if (t == 2) req[3] = 1'b1;
            end
            if (mode == 2) begin
                if (t == 2) start = 1'b0;
                if (t == 7) check("gate_idle_busy", 32'(busy), 32'd0);
                if (t == 10) start = 1'b1;
            end
        end
        req = '0;
    endtask

    typedef struct {
        int            core;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_rd;
        int            exp_we;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int            got_t;
        int            wcnt;
        logic [N-1:0]  gack;
        logic [DW-1:0] grd;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [1:0]    gid;

        tbl[0] = '{2, 1'b0, 8'h10, 16'h0000, 16'hBEEF, 0};
        tbl[1] = '{1, 1'b1, 8'h05, 16'h1234, 16'hBEEF, 1};
        tbl[2] = '{1, 1'b0, 8'h05, 16'h0000, 16'h1234, 0};
        tbl[3] = '{0, 1'b0, 8'h20, 16'h0000, 16'h0F0F, 0};
        tbl[4] = '{0, 1'b1, 8'h00, 16'h5A5A, 16'h0F0F, 1};
        tbl[5] = '{3, 1'b1, 8'hFF, 16'hABCD, 16'h0F0F, 1};
        tbl[6] = '{3, 1'b0, 8'hFF, 16'h0000, 16'hABCD, 0};

        reset_n = 1'b0; start = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        #12;
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        tick();
        reset_n = 1'b1;
        start = 1'b1;
        preload(8'h10, 16'hBEEF);
        preload(8'h20, 16'h0F0F);
        preload(8'h30, 16'h1000);
        preload(8'h31, 16'h1001);
        preload(8'h33, 16'h1003);

        for (int v = 0; v < 7; v++) begin
            set_core(tbl[v].core, tbl[v].w, tbl[v].a, tbl[v].d);
            req = '0;
            req[tbl[v].core] = 1'b1;
            tick();
            req = '0;
            got_t = -1; wcnt = 0; wa = '0; wd = '0; gack = '0; grd = '0; gid = '0;
            for (int t = 1; t <= 12 && got_t < 0; t++) begin
                tick();
                if (t == 1) gid = grant_id;
                if (mem_we) begin
                    wcnt++; wa = mem_addr; wd = mem_wdata;
                end
                if (ack != '0) begin
                    got_t = t; gack = ack; grd = rdata;
                end
            end
            check($sformatf("vec%0d_ack_edge", v), 32'(got_t), 32'd4);
            check($sformatf("vec%0d_ack_vec", v), 32'(gack), 32'(1) << tbl[v].core);
            check($sformatf("vec%0d_grant_id", v), 32'(gid), 32'(tbl[v].core));
            check($sformatf("vec%0d_rdata", v), 32'(grd), 32'(tbl[v].exp_rd));
            check($sformatf("vec%0d_we_cycles", v), 32'(wcnt), 32'(tbl[v].exp_we));
            if (tbl[v].w) begin
                check($sformatf("vec%0d_we_addr", v), 32'(wa), 32'(tbl[v].a));
                check($sformatf("vec%0d_we_data", v), 32'(wd), 32'(tbl[v].d));
            end
            tick();
            check($sformatf("vec%0d_ack_drop", v), 32'(ack), 32'd0);
            check($sformatf("vec%0d_idle", v), 32'(busy), 32'd0);
        end

        // Contention: cores 0,1,3 in one edge, pointer at 3 after the table.
        set_core(0, 1'b0, 8'h30, 16'h0);
        set_core(1, 1'b0, 8'h31, 16'h0);
        set_core(3, 1'b0, 8'h33, 16'h0);
        req = 4'b1011;
        tick();
        collect(16, 0);
        check("cont_n_acks", 32'(n_ev), 32'd3);
        check("cont_t0", 32'(ev_t[0]), 32'd4);
        check("cont_ack0", 32'(ev_ack[0]), 32'h1);
        check("cont_rd0", 32'(ev_rd[0]), 32'h1000);
        check("cont_t1", 32'(ev_t[1]), 32'd8);
        check("cont_ack1", 32'(ev_ack[1]), 32'h2);
        check("cont_rd1", 32'(ev_rd[1]), 32'h1001);
        check("cont_t2", 32'(ev_t[2]), 32'd12);
        check("cont_ack2", 32'(ev_ack[2]), 32'h8);
        check("cont_rd2", 32'(ev_rd[2]), 32'h1003);

        // Pointer left at 3: core 0 must beat core 2.
        set_core(2, 1'b0, 8'h10, 16'h0);
        req = 4'b0101;
        tick();
        collect(12, 0);
        check("ptr_ack0", 32'(ev_ack[0]), 32'h1);
        check("ptr_t1", 32'(ev_t[1]), 32'd8);
        check("ptr_ack1", 32'(ev_ack[1]), 32'h4);
        check("ptr_rd1", 32'(ev_rd[1]), 32'hBEEF);

        // Fairness: core 0 re-strobes in its ACK cycles; core 3 must get in between.
        req = 4'b0001;
        tick();
        collect(20, 1);
        check("fair_n_acks", 32'(n_ev), 32'd4);
        check("fair_t0", 32'(ev_t[0]), 32'd4);
        check("fair_ack0", 32'(ev_ack[0]), 32'h1);
        check("fair_t1", 32'(ev_t[1]), 32'd8);
        check("fair_ack1", 32'(ev_ack[1]), 32'h8);
        check("fair_t2", 32'(ev_t[2]), 32'd12);
        check("fair_ack2", 32'(ev_ack[2]), 32'h1);
        check("fair_t3", 32'(ev_t[3]), 32'd17);
        check("fair_ack3", 32'(ev_ack[3]), 32'h1);

        // Start gating: pointer at 0 so core 1 goes first; core 0 waits for start.
        req = 4'b0011;
        tick();
        collect(18, 2);
        check("gate_n_acks", 32'(n_ev), 32'd2);
        check("gate_t0", 32'(ev_t[0]), 32'd4);
        check("gate_ack0", 32'(ev_ack[0]), 32'h2);
        check("gate_t1", 32'(ev_t[1]), 32'd14);
        check("gate_ack1", 32'(ev_ack[1]), 32'h1);

        // Reset during the ISSUE cycle of a write with core 2 still queued.
        set_core(1, 1'b1, 8'h40, 16'h7777);
        set_core(2, 1'b0, 8'h10, 16'h0);
        req = 4'b0110;
        tick();
        req = '0;
        tick();
        check("rstmid_we_before", 32'(mem_we), 32'd1);
        check("rstmid_gid_before", 32'(grant_id), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rstmid_we", 32'(mem_we), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_ack", 32'(ack), 32'd0);
        check("rstmid_gid", 32'(grant_id), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        collect(8, 0);
        check("rstmid_no_ack", 32'(n_ev), 32'd0);
        check("rstmid_idle", 32'(busy), 32'd0);
        set_core(0, 1'b0, 8'h30, 16'h0);
        req = 4'b0101;
        tick();
        collect(10, 0);
        check("rstmid_first_t", 32'(ev_t[0]), 32'd4);
        check("rstmid_first_ack", 32'(ev_ack[0]), 32'h1);
        check("rstmid_first_rd", 32'(ev_rd[0]), 32'h1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
